// File: rtl/console_pkg.sv
// Shared types and constants for the text console stream writer.
package console_pkg;

  localparam int unsigned NumRowsDefault = 3;
  localparam int unsigned NumColsDefault = 10;

  // Control codes recognised in the byte stream.
  localparam logic [7:0] CH_BS         = 8'h08;
  localparam logic [7:0] CH_LF         = 8'h0A;
  localparam logic [7:0] CH_FF         = 8'h0C;
  localparam logic [7:0] CH_CR         = 8'h0D;
  localparam logic [7:0] CH_COLOR_BASE = 8'h10;
  localparam logic [7:0] CH_SPACE      = 8'h20;
  localparam logic [7:0] CH_TILDE      = 8'h7E;

  typedef enum logic [1:0] {
    StIdle,
    StScroll,
    StClearRow,
    StClearAll
  } state_e;

  // One character cell as stored in the text buffer.
  typedef struct packed {
    logic [1:0] color;
    logic [6:0] ascii;
  } cell_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor row/column tracking with an incrementally maintained linear address.
// Optional build macro: CONSOLE_LF_IMPLIES_CR_EN (LF also returns to column 0).
module console_cursor import console_pkg::*; #(
  parameter int unsigned NUM_ROWS = NumRowsDefault,
  parameter int unsigned NUM_COLS = NumColsDefault,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance_i,
  input  logic              newline_i,
  input  logic              cr_i,
  input  logic              back_i,
  input  logic              home_i,
  output logic              at_eol_o,
  output logic              needs_scroll_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int unsigned ColW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned RowW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ColW-1:0]   LastCol = ColW'(NUM_COLS - 1);
  localparam logic [RowW-1:0]   LastRow = RowW'(NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] ColsA   = ADDR_W'(NUM_COLS);
  localparam logic [ADDR_W-1:0] ColsM1A = ADDR_W'(NUM_COLS - 1);

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] line_base;

  assign at_eol_o       = (col_q == LastCol);
  assign needs_scroll_o = (row_q == LastRow);
  assign addr_o         = addr_q;

  // Next cursor position; address tracks row*NUM_COLS+col by add/subtract only.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    addr_d    = addr_q;
    line_base = addr_q;
    if (home_i) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance_i) begin
      if (col_q != LastCol) begin
        col_d  = col_q + ColW'(1);
        addr_d = addr_q + ADDR_W'(1);
      end else begin
        col_d = '0;
        if (row_q != LastRow) begin
          row_d  = row_q + RowW'(1);
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          // Last row stays put; the buffer scrolls underneath it.
          addr_d = addr_q - ColsM1A;
        end
      end
    end else if (newline_i) begin
`ifdef CONSOLE_LF_IMPLIES_CR_EN
      col_d     = '0;
      line_base = addr_q - ADDR_W'(col_q);
`else
      line_base = addr_q;
`endif
      if (row_q != LastRow) begin
        row_d  = row_q + RowW'(1);
        addr_d = line_base + ColsA;
      end else begin
        addr_d = line_base;
      end
    end else if (cr_i) begin
      col_d  = '0;
      addr_d = addr_q - ADDR_W'(col_q);
    end else if (back_i && (col_q != '0)) begin
      col_d  = col_q - ColW'(1);
      addr_d = addr_q - ADDR_W'(1);
    end
  end

  // Cursor state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/console_stream_writer.sv
// Byte-stream front-end that turns ASCII and control codes into text buffer writes.
// Optional build macro: CONSOLE_LF_IMPLIES_CR_EN (handled in console_cursor).
module console_stream_writer import console_pkg::*; #(
  parameter int unsigned NUM_ROWS      = NumRowsDefault,
  parameter int unsigned NUM_COLS      = NumColsDefault,
  parameter int unsigned ADDR_W        = 5,
  parameter logic [1:0]  DEFAULT_COLOR = 2'b00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [8:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [8:0]        buf_rdata,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ColsA       = ADDR_W'(NUM_COLS);
  localparam logic [ADDR_W-1:0] ScrollLast  = ADDR_W'((NUM_ROWS - 1) * NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] LastRowBase = ADDR_W'((NUM_ROWS - 1) * NUM_COLS);
  localparam logic [ADDR_W-1:0] CellLast    = ADDR_W'(NUM_ROWS * NUM_COLS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [1:0]        color_q, color_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  cell_t             wdata_q, wdata_d;

  logic cur_adv, cur_nl, cur_cr, cur_back, cur_home;
  logic at_eol, needs_scroll;
  logic xfer, is_print;

  console_cursor #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS),
    .ADDR_W   (ADDR_W)
  ) u_cursor (
    .clk            (clk),
    .reset          (reset),
    .advance_i      (cur_adv),
    .newline_i      (cur_nl),
    .cr_i           (cur_cr),
    .back_i         (cur_back),
    .home_i         (cur_home),
    .at_eol_o       (at_eol),
    .needs_scroll_o (needs_scroll),
    .addr_o         (cursor_addr)
  );

  assign in_ready  = (state_q == StIdle) && !reset;
  assign busy      = (state_q != StIdle);
  assign xfer      = in_valid && in_ready;
  assign is_print  = (in_data >= CH_SPACE) && (in_data <= CH_TILDE);
  assign buf_we    = we_q;
  assign buf_addr  = addr_q;
  assign buf_wdata = wdata_q;
  // Read address is only meaningful while copying rows up.
  assign buf_raddr = (state_q == StScroll) ? (k_q + ColsA) : '0;

  // Byte decode, scroll/clear sequencing and the registered write port.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    color_d  = color_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cur_adv  = 1'b0;
    cur_nl   = 1'b0;
    cur_cr   = 1'b0;
    cur_back = 1'b0;
    cur_home = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (is_print) begin
            we_d          = 1'b1;
            addr_d        = cursor_addr;
            wdata_d.color = color_q;
            wdata_d.ascii = in_data[6:0];
            cur_adv       = 1'b1;
            if (at_eol && needs_scroll) begin
              state_d = StScroll;
              k_d     = '0;
            end
          end else if (in_data == CH_CR) begin
            cur_cr = 1'b1;
          end else if (in_data == CH_LF) begin
            cur_nl = 1'b1;
            if (needs_scroll) begin
              state_d = StScroll;
              k_d     = '0;
            end
          end else if (in_data == CH_BS) begin
            cur_back = 1'b1;
          end else if (in_data == CH_FF) begin
            cur_home = 1'b1;
            state_d  = StClearAll;
            k_d      = '0;
          end else if (in_data[7:2] == CH_COLOR_BASE[7:2]) begin
            color_d = in_data[1:0];
          end
        end
      end
      StScroll: begin
        // Cell k+NUM_COLS was read this cycle; it lands at k next cycle.
        we_d    = 1'b1;
        addr_d  = k_q;
        wdata_d = cell_t'(buf_rdata);
        if (k_q == ScrollLast) begin
          state_d = StClearRow;
          k_d     = LastRowBase;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end
      StClearRow, StClearAll: begin
        we_d          = 1'b1;
        addr_d        = k_q;
        wdata_d.color = color_q;
        wdata_d.ascii = CH_SPACE[6:0];
        if (k_q == CellLast) begin
          state_d = StIdle;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, colour and write pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      color_q <= DEFAULT_COLOR;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      color_q <= color_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_console_stream_writer.sv
// Directed bench for console_stream_writer with a behavioural text buffer.
module tb_console_stream_writer;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [8:0]    buf_wdata;
  logic [AW-1:0] buf_raddr;
  logic [8:0]    buf_rdata;
  logic [AW-1:0] cursor_addr;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  console_stream_writer #(
    .NUM_ROWS      (3),
    .NUM_COLS      (10),
    .ADDR_W        (AW),
    .DEFAULT_COLOR (2'b00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .buf_we      (buf_we),
    .buf_addr    (buf_addr),
    .buf_wdata   (buf_wdata),
    .buf_raddr   (buf_raddr),
    .buf_rdata   (buf_rdata),
    .cursor_addr (cursor_addr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Text buffer: combinational read, writes captured away from the active edge.
  logic [8:0]  mem [0:31];
  int unsigned wr_cnt = 0;
  assign buf_rdata = mem[buf_raddr];

  always @(negedge clk) begin
    if (buf_we) begin
      mem[buf_addr] <= buf_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check_val("ready_timeout", 32'(in_ready), 1);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts cycles with in_ready low, then lets the final write reach the buffer.
  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic pulse_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int          n;
    int          bad;
    int unsigned exp_cell;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state.
    #12;
    check_val("rst_in_ready", 32'(in_ready), 0);
    check_val("rst_we", 32'(buf_we), 0);
    check_val("rst_addr", 32'(buf_addr), 0);
    check_val("rst_wdata", 32'(buf_wdata), 0);
    check_val("rst_raddr", 32'(buf_raddr), 0);
    check_val("rst_cursor", 32'(cursor_addr), 0);
    check_val("rst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_val("post_rst_ready", 32'(in_ready), 1);

    // "AB" -> two writes at 0 and 1.
    base = wr_cnt;
    send_byte(8'h41);
    check_val("A_we", 32'(buf_we), 1);
    check_val("A_addr", 32'(buf_addr), 0);
    check_val("A_data", 32'(buf_wdata), 32'h041);
    send_byte(8'h42);
    check_val("B_addr", 32'(buf_addr), 1);
    check_val("B_data", 32'(buf_wdata), 32'h042);
    tick();
    check_val("AB_writes", wr_cnt - base, 2);
    check_val("AB_cursor", 32'(cursor_addr), 2);

    // Colour select, CR, BS at column 0, and ignored bytes.
    send_byte(8'h0D);
    check_val("cr_cursor", 32'(cursor_addr), 0);
    base = wr_cnt;
    send_byte(8'h12);
    send_byte(8'h58);
    check_val("X_addr", 32'(buf_addr), 0);
    check_val("X_data", 32'(buf_wdata), 32'h158);
    check_val("X_cursor", 32'(cursor_addr), 1);
    send_byte(8'h0D);
    check_val("cr2_cursor", 32'(cursor_addr), 0);
    send_byte(8'h08);
    check_val("bs_col0_cursor", 32'(cursor_addr), 0);
    send_byte(8'h80);
    send_byte(8'h7F);
    send_byte(8'h01);
    send_byte(8'h14);
    tick();
    check_val("nonprint_writes", wr_cnt - base, 1);
    check_val("nonprint_cursor", 32'(cursor_addr), 0);
    check_val("nonprint_busy", 32'(busy), 0);

    // Fill all 30 cells from home; the last one triggers a scroll.
    pulse_reset();
    base = wr_cnt;
    for (int i = 0; i < 30; i++) send_byte(8'(8'h61 + i));
    check_val("fill_last_addr", 32'(buf_addr), 29);
    wait_ready(n);
    check_val("fill_ready_low", 32'(n), 30);
    check_val("fill_writes", wr_cnt - base, 60);
    check_val("fill_cursor", 32'(cursor_addr), 20);
    check_val("fill_busy", 32'(busy), 0);
    for (int a = 0; a < 30; a++) begin
      if (a < 10)      exp_cell = 32'h6B + 32'(a);
      else if (a < 20) exp_cell = 32'h75 + 32'(a - 10);
      else             exp_cell = 32'h020;
      check_val($sformatf("fill_cell%0d", a), 32'(mem[a]), exp_cell);
    end

    // LF / BS / CR cursor arithmetic, then LF on the last row scrolls.
    pulse_reset();
    for (int i = 0; i < 4; i++) send_byte(8'h61);
    check_val("col4_cursor", 32'(cursor_addr), 4);
    send_byte(8'h0A);
`ifdef CONSOLE_LF_IMPLIES_CR_EN
    check_val("lf_cursor", 32'(cursor_addr), 10);
    send_byte(8'h08);
    check_val("bs_cursor", 32'(cursor_addr), 10);
`else
    check_val("lf_cursor", 32'(cursor_addr), 14);
    send_byte(8'h08);
    check_val("bs_cursor", 32'(cursor_addr), 13);
`endif
    send_byte(8'h0D);
    check_val("cr_row1_cursor", 32'(cursor_addr), 10);
    send_byte(8'h0A);
    check_val("lf_row2_cursor", 32'(cursor_addr), 20);
    base = wr_cnt;
    send_byte(8'h0A);
    check_val("lf_scroll_busy", 32'(busy), 1);
    wait_ready(n);
    check_val("lf_scroll_ready_low", 32'(n), 30);
    check_val("lf_scroll_writes", wr_cnt - base, 30);
    check_val("lf_scroll_cursor", 32'(cursor_addr), 20);

    // FF in colour 3: 30 back-to-back clears of {11,0x20}.
    send_byte(8'h13);
    send_byte(8'h0C);
    check_val("ff_busy_start", 32'(busy), 1);
    check_val("ff_we_start", 32'(buf_we), 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!(buf_we && (32'(buf_addr) == 32'(i)) && (buf_wdata == 9'h1A0))) bad++;
      if ((i < 29) && !busy) bad++;
    end
    check_val("ff_sequence_bad", 32'(bad), 0);
    check_val("ff_busy_end", 32'(busy), 0);
    check_val("ff_cursor", 32'(cursor_addr), 0);
    tick();
    check_val("ff_cell0", 32'(mem[0]), 32'h1A0);
    check_val("ff_cell29", 32'(mem[29]), 32'h1A0);

    // Asynchronous reset in the fifth scroll cycle.
    pulse_reset();
    send_byte(8'h0A);
    send_byte(8'h0A);
    send_byte(8'h0A);
    repeat (4) tick();
    check_val("mid_scroll_we", 32'(buf_we), 1);
    check_val("mid_scroll_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check_val("abort_we", 32'(buf_we), 0);
    check_val("abort_busy", 32'(busy), 0);
    check_val("abort_in_ready", 32'(in_ready), 0);
    check_val("abort_cursor", 32'(cursor_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_val("abort_ready_after", 32'(in_ready), 1);
    send_byte(8'h5A);
    check_val("Z_we", 32'(buf_we), 1);
    check_val("Z_addr", 32'(buf_addr), 0);
    check_val("Z_data", 32'(buf_wdata), 32'h05A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
